// File: rtl/imacf.sv
// Iterative fractional multiply-accumulate unit.
// One multiplier bit is consumed per RUN cycle (LSB first, shift-add). The
// b[bits] step subtracts when b is signed, and a closing RUN cycle writes the
// product (or p + product) back into p.
// Optional feature: define IMACF_SATURATE_EN to clamp p on accumulate overflow
// instead of wrapping modulo 2^(2W).
module imacf #(
  parameter int unsigned WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     go,
  input  logic                     sign_a,
  input  logic                     sign_b,
  input  logic                     acc,
  input  logic [$clog2(WIDTH)-1:0] bits,
  input  logic [WIDTH-1:0]         a,
  input  logic [WIDTH-1:0]         b,
  output logic                     busy,
  output logic                     done,
  output logic                     ovf,
  output logic [2*WIDTH-1:0]       p
);

  localparam int unsigned BW = $clog2(WIDTH);
  localparam int unsigned CW = BW + 1;
  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BW-1:0]    bits_q, bits_d;
  logic             sgnb_q, sgnb_d;
  logic             acc_q, acc_d;
  logic             smode_q, smode_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [PW-1:0]    addend_q, addend_d;
  logic [PW-1:0]    prod_q, prod_d;
  logic [PW-1:0]    p_q, p_d;
  logic             ovf_q, ovf_d;

  logic [BW-1:0]    bits_c;
  logic [CW-1:0]    shamt;
  logic [PW-1:0]    a_ext;
  logic [PW:0]      sum;
  logic             acc_ovf;
  logic [PW-1:0]    acc_res;
  logic [CW-1:0]    last_cnt;
  logic [CW-1:0]    wb_cnt;

  // Operand preparation at capture: align A so that the final (MSB) step lands
  // on 2^(W-1), which scales the result by 2^(W-bits-1).
  always_comb begin
    // bits beyond W-1 can only occur for non-power-of-two W; clamp them
    if ({1'b0, bits} > CW'(WIDTH - 1)) begin
      bits_c = BW'(WIDTH - 1);
    end else begin
      bits_c = bits;
    end
    shamt = CW'(WIDTH - 1) - {1'b0, bits_c};
    a_ext = sign_a ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
  end

  // Accumulate path: p + product with overflow detection and optional clamp.
  always_comb begin
    sum = {1'b0, p_q} + {1'b0, prod_q};
    if (smode_q) begin
      acc_ovf = (p_q[PW-1] == prod_q[PW-1]) && (sum[PW-1] != p_q[PW-1]);
    end else begin
      acc_ovf = sum[PW];
    end
    acc_res = sum[PW-1:0];
`ifdef IMACF_SATURATE_EN
    if (acc_ovf) begin
      if (smode_q) begin
        // both operands share a sign on signed overflow; clamp toward it
        acc_res = p_q[PW-1] ? {1'b1, {(PW-1){1'b0}}} : {1'b0, {(PW-1){1'b1}}};
      end else begin
        acc_res = '1;
      end
    end
`endif
  end

  // Iteration bookkeeping: steps 0..bits iterate, step bits+1 writes back.
  always_comb begin
    last_cnt = {1'b0, bits_q};
    wb_cnt   = {1'b0, bits_q} + CW'(1);
  end

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bits_d   = bits_q;
    sgnb_d   = sgnb_q;
    acc_d    = acc_q;
    smode_d  = smode_q;
    b_d      = b_q;
    addend_d = addend_q;
    prod_d   = prod_q;
    p_d      = p_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (go) begin
          state_d  = StRun;
          cnt_d    = '0;
          bits_d   = bits_c;
          sgnb_d   = sign_b;
          acc_d    = acc;
          smode_d  = sign_a | sign_b;
          b_d      = b;
          addend_d = a_ext << shamt;
          prod_d   = '0;
          ovf_d    = 1'b0;
        end
      end
      StRun: begin
        if (cnt_q == wb_cnt) begin
          p_d     = acc_q ? acc_res : prod_q;
          ovf_d   = acc_q & acc_ovf;
          state_d = StDone;
        end else begin
          if (b_q[0]) begin
            // the sign bit of a two's complement multiplier has negative weight
            if (sgnb_q && (cnt_q == last_cnt)) begin
              prod_d = prod_q - addend_q;
            end else begin
              prod_d = prod_q + addend_q;
            end
          end
          b_d      = b_q >> 1;
          addend_d = addend_q << 1;
          cnt_d    = cnt_q + CW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      bits_q   <= '0;
      sgnb_q   <= 1'b0;
      acc_q    <= 1'b0;
      smode_q  <= 1'b0;
      b_q      <= '0;
      addend_q <= '0;
      prod_q   <= '0;
      p_q      <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bits_q   <= bits_d;
      sgnb_q   <= sgnb_d;
      acc_q    <= acc_d;
      smode_q  <= smode_d;
      b_q      <= b_d;
      addend_q <= addend_d;
      prod_q   <= prod_d;
      p_q      <= p_d;
      ovf_q    <= ovf_d;
    end
  end

  // Outputs decode directly from registered state.
  always_comb begin
    busy = (state_q == StRun);
    done = (state_q == StDone);
    ovf  = ovf_q;
    p    = p_q;
  end

endmodule
